// File: rtl/dmem_responder_if.sv
// ---------------------------------------------------------------------------
// dmem_responder_if
// Request/response bundle between a load/store unit (master) and the data
// memory responder (slave).
//   req_valid / req_ready      : request handshake
//   RAM_write_en / RAM_read_en : store / load request (store wins if both)
//   RAM_ram_type / RAM_sign    : access width encoding, load sign extension
//   addr / wdata               : byte address, right-aligned store data
//   rdata / rdata_valid        : extended load result and its 1-cycle strobe
//   stall                      : pipeline hold while an access is in flight
//   misaligned_err             : 1-cycle strobe for a rejected misaligned access
// ---------------------------------------------------------------------------
interface dmem_responder_if;
   logic        req_valid;
   logic        req_ready;
   logic        RAM_write_en;
   logic        RAM_read_en;
   logic [3:0]  RAM_ram_type;
   logic        RAM_sign;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        rdata_valid;
   logic        stall;
   logic        misaligned_err;

   modport master (
      output req_valid, RAM_write_en, RAM_read_en, RAM_ram_type, RAM_sign,
             addr, wdata,
      input  req_ready, rdata, rdata_valid, stall, misaligned_err
   );

   modport slave (
      input  req_valid, RAM_write_en, RAM_read_en, RAM_ram_type, RAM_sign,
             addr, wdata,
      output req_ready, rdata, rdata_valid, stall, misaligned_err
   );
endinterface

// File: rtl/dmem_responder.sv
// ---------------------------------------------------------------------------
// dmem_responder
// Word-organised data RAM with byte/halfword/word loads and stores.
// Ports:
//   clk  : single clock, rising edge
//   rst  : asynchronous active-high reset (control state only, RAM untouched)
//   bus  : dmem_responder_if.slave request/response bundle
// Parameters:
//   DEPTH_WORDS : number of 32-bit RAM words (word index = addr[31:2] mod depth)
//   INIT_ZERO   : nonzero clears the RAM image at elaboration
// Build option:
//   MISALIGNED_SPLIT_EN : when defined, misaligned accesses are split across
//   word N (accepting edge) and word N+1 (ACC2). When undefined, misaligned
//   stores are dropped and misaligned loads return 0, both with misaligned_err.
// Access width encodings: BYTE 4'b0001, HALFWORD 4'b0011, FULLWORD 4'b1111;
// any other value is accepted but performs no RAM access.
// ---------------------------------------------------------------------------
module dmem_responder #(
   parameter int DEPTH_WORDS = 1024,
   parameter int INIT_ZERO   = 1
) (
   input  logic            clk,
   input  logic            rst,
   dmem_responder_if.slave bus
);
   localparam logic [3:0]  BYTE     = 4'b0001;
   localparam logic [3:0]  HALFWORD = 4'b0011;
   localparam logic [3:0]  FULLWORD = 4'b1111;
   localparam int          IW       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam logic [31:0] MEM_INIT = (INIT_ZERO != 0) ? 32'h0000_0000 : 32'hxxxx_xxxx;
`ifdef MISALIGNED_SPLIT_EN
   localparam bit          SPLIT    = 1'b1;
   localparam int          LW       = 64;
`else
   localparam bit          SPLIT    = 1'b0;
   localparam int          LW       = 32;
`endif

   typedef enum logic [1:0] {IDLE, ACC2, RESP} state_t;

   logic [31:0]     r_mem [DEPTH_WORDS] = '{default: MEM_INIT};

   state_t          r_state;
   logic            r_req_ready;
   logic            r_stall;
   logic            r_rdata_valid;
   logic            r_misaligned_err;
   logic [31:0]     r_rdata;

   logic            w_accept;
   logic            w_wr;
   logic            w_known;
   logic            w_aligned;
   logic            w_go;
   logic [1:0]      w_off;
   logic [3:0]      w_base_be;
   logic [IW-1:0]   w_idx0;
   logic [LW-1:0]   w_wd_sh;
   logic [LW/8-1:0] w_be_sh;
   logic [3:0]      w_mem_be;
   logic [IW-1:0]   w_mem_idx;
   logic [31:0]     w_mem_wd;

   // Shift the addressed lanes down to bit 0 and extend to 32 bits.
   function automatic logic [31:0] f_extract(input logic [63:0] d, input logic [1:0] off,
                                             input logic [3:0] typ, input logic sgn);
      logic [31:0] s;
      s = 32'(d >> {off, 3'b000});
      case (typ)
         BYTE:     return sgn ? {{24{s[7]}}, s[7:0]} : {24'h0, s[7:0]};
         HALFWORD: return sgn ? {{16{s[15]}}, s[15:0]} : {16'h0, s[15:0]};
         FULLWORD: return s;
         default:  return 32'h0;
      endcase
   endfunction

   always_comb begin
      w_base_be = 4'b0000;
      w_aligned = 1'b0;
      case (bus.RAM_ram_type)
         BYTE:     begin w_base_be = 4'b0001; w_aligned = 1'b1;                  end
         HALFWORD: begin w_base_be = 4'b0011; w_aligned = ~bus.addr[0];          end
         FULLWORD: begin w_base_be = 4'b1111; w_aligned = (bus.addr[1:0] == 2'b00); end
         default:  ;
      endcase
   end

   assign w_known  = |w_base_be;
   assign w_go     = w_known & (w_aligned | SPLIT);
   assign w_off    = bus.addr[1:0];
   assign w_wr     = bus.RAM_write_en;
   // Accepts are blocked while rst is high so no RAM write slips in during reset.
   assign w_accept = r_req_ready & bus.req_valid & (bus.RAM_read_en | bus.RAM_write_en) & ~rst;
   assign w_idx0   = IW'(32'(bus.addr[31:2]) % 32'(DEPTH_WORDS));
   // Lane-aligned store data/enables; in the split build the upper word is word N+1.
   assign w_wd_sh  = LW'(bus.wdata) << {w_off, 3'b000};
   assign w_be_sh  = (LW/8)'(w_base_be) << w_off;

`ifdef MISALIGNED_SPLIT_EN
   logic            r_is_load;
   logic            r_sign;
   logic [1:0]      r_off;
   logic [3:0]      r_type;
   logic [3:0]      r_hi_be;
   logic [IW-1:0]   r_idx1;
   logic [31:0]     r_lo_word;
   logic [31:0]     r_hi_wd;
   logic [IW-1:0]   w_idx1;

   assign w_idx1 = (w_idx0 == IW'(DEPTH_WORDS - 1)) ? '0 : w_idx0 + IW'(1);

   // Context for the second half of a split access, captured at acceptance.
   always_ff @(posedge clk) begin
      if (w_accept && w_known && !w_aligned) begin
         r_is_load <= ~w_wr;
         r_sign    <= bus.RAM_sign;
         r_off     <= w_off;
         r_type    <= bus.RAM_ram_type;
         r_idx1    <= w_idx1;
         r_lo_word <= r_mem[w_idx0];
         r_hi_be   <= w_be_sh[7:4];
         r_hi_wd   <= w_wd_sh[63:32];
      end
   end
`endif

   // Single RAM write port: first half at acceptance, second half in ACC2.
   always_comb begin
      w_mem_be  = 4'b0000;
      w_mem_idx = w_idx0;
      w_mem_wd  = w_wd_sh[31:0];
      if (w_accept && w_wr && w_go) w_mem_be = w_be_sh[3:0];
`ifdef MISALIGNED_SPLIT_EN
      if (r_state == ACC2 && !r_is_load) begin
         w_mem_be  = r_hi_be;
         w_mem_idx = r_idx1;
         w_mem_wd  = r_hi_wd;
      end
`endif
   end

   always_ff @(posedge clk) begin
      for (int b = 0; b < 4; b++) begin
         if (w_mem_be[b]) r_mem[w_mem_idx][8*b +: 8] <= w_mem_wd[8*b +: 8];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state          <= IDLE;
         r_req_ready      <= 1'b1;
         r_stall          <= 1'b0;
         r_rdata_valid    <= 1'b0;
         r_misaligned_err <= 1'b0;
         r_rdata          <= 32'h0;
      end else begin
         r_rdata_valid    <= 1'b0;
         r_misaligned_err <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  if (w_known && !w_aligned && SPLIT) begin
                     r_state     <= ACC2;
                     r_stall     <= 1'b1;
                     r_req_ready <= 1'b0;
                  end else begin
                     // Misaligned without split support is flagged and never touches RAM.
                     if (w_known && !w_aligned) r_misaligned_err <= 1'b1;
                     if (!w_wr) begin
                        r_rdata       <= w_go ? f_extract({32'h0, r_mem[w_idx0]}, w_off,
                                                          bus.RAM_ram_type, bus.RAM_sign)
                                              : 32'h0;
                        r_rdata_valid <= 1'b1;
                        r_state       <= RESP;
                        r_stall       <= 1'b1;
                        r_req_ready   <= 1'b0;
                     end
                  end
               end
            end
            ACC2: begin
`ifdef MISALIGNED_SPLIT_EN
               if (r_is_load) begin
                  r_rdata       <= f_extract({r_mem[r_idx1], r_lo_word}, r_off, r_type, r_sign);
                  r_rdata_valid <= 1'b1;
                  r_state       <= RESP;
               end else begin
                  r_state     <= IDLE;
                  r_stall     <= 1'b0;
                  r_req_ready <= 1'b1;
               end
`else
               r_state     <= IDLE;
               r_stall     <= 1'b0;
               r_req_ready <= 1'b1;
`endif
            end
            default: begin
               r_state     <= IDLE;
               r_stall     <= 1'b0;
               r_req_ready <= 1'b1;
            end
         endcase
      end
   end

   assign bus.req_ready      = r_req_ready;
   assign bus.stall          = r_stall;
   assign bus.rdata          = r_rdata;
   assign bus.rdata_valid    = r_rdata_valid;
   assign bus.misaligned_err = r_misaligned_err;
endmodule

// File: tb/tb_dmem_responder.sv
// ---------------------------------------------------------------------------
// tb_dmem_responder
// Drives two responders in lockstep: A with 1024 words, B with 4 words so that
// index wrap-around and address aliasing can be observed. Expectations for
// misaligned accesses follow the MISALIGNED_SPLIT_EN build option.
// ---------------------------------------------------------------------------
module tb_dmem_responder;
   localparam logic [3:0] BYTE = 4'b0001;
   localparam logic [3:0] HALF = 4'b0011;
   localparam logic [3:0] FULL = 4'b1111;
   localparam logic [3:0] UNK  = 4'b0100;
`ifdef MISALIGNED_SPLIT_EN
   localparam bit SPLIT = 1'b1;
`else
   localparam bit SPLIT = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst;
   int   n_cmp = 0;
   int   n_bad = 0;

   dmem_responder_if bus_a ();
   dmem_responder_if bus_b ();

   dmem_responder #(.DEPTH_WORDS(1024), .INIT_ZERO(1)) u_dut_a (.clk(clk), .rst(rst), .bus(bus_a));
   dmem_responder #(.DEPTH_WORDS(4),    .INIT_ZERO(1)) u_dut_b (.clk(clk), .rst(rst), .bus(bus_b));

   always #5 clk = ~clk;

   typedef struct {
      logic        wr;
      logic        rd;
      logic [3:0]  typ;
      logic        sgn;
      logic [31:0] addr;
      logic [31:0] wdata;
      int          lat;     // cycle after acceptance carrying rdata_valid (0 = none)
      int          nst;     // number of stall cycles after acceptance
      logic [31:0] exp_a;
      logic        chk_b;
      logic [31:0] exp_b;
      logic        err;
   } vec_t;

   vec_t vt[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic drive(input logic v, input logic wr, input logic rd, input logic [3:0] typ,
                        input logic sg, input logic [31:0] a, input logic [31:0] wd);
      bus_a.req_valid = v;  bus_a.RAM_write_en = wr; bus_a.RAM_read_en = rd;
      bus_a.RAM_ram_type = typ; bus_a.RAM_sign = sg; bus_a.addr = a; bus_a.wdata = wd;
      bus_b.req_valid = v;  bus_b.RAM_write_en = wr; bus_b.RAM_read_en = rd;
      bus_b.RAM_ram_type = typ; bus_b.RAM_sign = sg; bus_b.addr = a; bus_b.wdata = wd;
   endtask

   function automatic vec_t mk(input logic wr, input logic rd, input logic [3:0] typ, input logic sg,
                               input logic [31:0] a, input logic [31:0] wd, input int lat, input int nst,
                               input logic [31:0] ea, input logic cb, input logic [31:0] eb,
                               input logic err);
      vec_t v;
      v.wr = wr; v.rd = rd; v.typ = typ; v.sgn = sg; v.addr = a; v.wdata = wd;
      v.lat = lat; v.nst = nst; v.exp_a = ea; v.chk_b = cb; v.exp_b = eb; v.err = err;
      return v;
   endfunction

   function automatic vec_t st(input logic [3:0] typ, input logic [31:0] a, input logic [31:0] wd);
      return mk(1'b1, 1'b0, typ, 1'b0, a, wd, 0, 0, 32'h0, 1'b0, 32'h0, 1'b0);
   endfunction

   function automatic vec_t ld(input logic [3:0] typ, input logic sg, input logic [31:0] a,
                               input logic [31:0] ea);
      return mk(1'b0, 1'b1, typ, sg, a, 32'h0, 1, 1, ea, 1'b0, 32'h0, 1'b0);
   endfunction

   task automatic run_vec(input int k, input vec_t v);
      int n = 0;
      while (bus_a.req_ready !== 1'b1 && n < 8) begin
         @(negedge clk);
         n++;
      end
      chk($sformatf("v%0d_ready", k), {31'h0, bus_a.req_ready}, 32'h1);
      drive(1'b1, v.wr, v.rd, v.typ, v.sgn, v.addr, v.wdata);
      @(posedge clk);
      #1;
      drive(1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 32'h0, 32'h0);
      for (int c = 1; c <= 3; c++) begin
         @(negedge clk);
         chk($sformatf("v%0d_c%0d_stall", k, c), {31'h0, bus_a.stall}, {31'h0, c <= v.nst});
         chk($sformatf("v%0d_c%0d_valid", k, c), {31'h0, bus_a.rdata_valid}, {31'h0, c == v.lat});
         chk($sformatf("v%0d_c%0d_err", k, c), {31'h0, bus_a.misaligned_err},
             {31'h0, v.err && c == 1});
         if (v.lat != 0 && (c == v.lat || c == v.lat + 1)) begin
            chk($sformatf("v%0d_c%0d_rdata", k, c), bus_a.rdata, v.exp_a);
            if (v.chk_b) chk($sformatf("v%0d_c%0d_rdata_b", k, c), bus_b.rdata, v.exp_b);
         end
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      rst = 1'b1;
      drive(1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 32'h0, 32'h0);

      vt.push_back(st(FULL, 32'h10, 32'h8000_00F0));
      vt.push_back(ld(BYTE, 1'b1, 32'h10, 32'hFFFF_FFF0));
      vt.push_back(ld(BYTE, 1'b0, 32'h10, 32'h0000_00F0));
      vt.push_back(ld(HALF, 1'b1, 32'h12, 32'hFFFF_8000));
      vt.push_back(st(FULL, 32'h20, 32'h1234_5678));
      vt.push_back(st(BYTE, 32'h21, 32'hFFFF_FFAB));
      vt.push_back(ld(FULL, 1'b0, 32'h20, 32'h1234_AB78));
      vt.push_back(ld(HALF, 1'b0, 32'h22, 32'h0000_1234));
      vt.push_back(ld(BYTE, 1'b1, 32'h23, 32'h0000_0012));
      vt.push_back(ld(BYTE, 1'b1, 32'h21, 32'hFFFF_FFAB));
      vt.push_back(st(FULL, 32'h24, 32'h0102_0304));
      vt.push_back(st(HALF, 32'h26, 32'h1111_BEEF));
      vt.push_back(ld(FULL, 1'b0, 32'h24, 32'hBEEF_0304));
      vt.push_back(ld(HALF, 1'b1, 32'h24, 32'h0000_0304));
      vt.push_back(mk(1'b1, 1'b1, FULL, 1'b0, 32'h30, 32'hDEAD_BEEF, 0, 0, 32'h0, 1'b0, 32'h0, 1'b0));
      vt.push_back(ld(FULL, 1'b0, 32'h30, 32'hDEAD_BEEF));
      vt.push_back(mk(1'b0, 1'b1, UNK, 1'b0, 32'h30, 32'h0, 1, 1, 32'h0, 1'b0, 32'h0, 1'b0));
      vt.push_back(mk(1'b1, 1'b0, UNK, 1'b0, 32'h30, 32'h0, 0, 0, 32'h0, 1'b0, 32'h0, 1'b0));
      vt.push_back(ld(FULL, 1'b0, 32'h30, 32'hDEAD_BEEF));
      vt.push_back(st(FULL, 32'h04, 32'h1122_3344));
      vt.push_back(st(FULL, 32'h08, 32'h5566_7788));
`ifdef MISALIGNED_SPLIT_EN
      vt.push_back(mk(1'b0, 1'b1, FULL, 1'b0, 32'h06, 32'h0, 2, 2, 32'h7788_1122, 1'b0, 32'h0, 1'b0));
      vt.push_back(mk(1'b1, 1'b0, FULL, 1'b0, 32'h09, 32'hA5A5_A5A5, 0, 1, 32'h0, 1'b0, 32'h0, 1'b0));
      vt.push_back(ld(FULL, 1'b0, 32'h08, 32'hA5A5_A588));
      vt.push_back(mk(1'b0, 1'b1, HALF, 1'b1, 32'h09, 32'h0, 2, 2, 32'hFFFF_A5A5, 1'b0, 32'h0, 1'b0));
`else
      vt.push_back(mk(1'b0, 1'b1, FULL, 1'b0, 32'h06, 32'h0, 1, 1, 32'h0, 1'b0, 32'h0, 1'b1));
      vt.push_back(mk(1'b1, 1'b0, FULL, 1'b0, 32'h09, 32'hA5A5_A5A5, 0, 0, 32'h0, 1'b0, 32'h0, 1'b1));
      vt.push_back(ld(FULL, 1'b0, 32'h08, 32'h5566_7788));
      vt.push_back(mk(1'b0, 1'b1, HALF, 1'b1, 32'h09, 32'h0, 1, 1, 32'h0, 1'b0, 32'h0, 1'b1));
`endif
      vt.push_back(st(FULL, 32'h0C, 32'h4433_2211));
      vt.push_back(st(FULL, 32'h00, 32'h8877_6655));
`ifdef MISALIGNED_SPLIT_EN
      vt.push_back(mk(1'b0, 1'b1, HALF, 1'b1, 32'h0F, 32'h0, 2, 2, 32'hFFFF_F044, 1'b1, 32'h0000_5544, 1'b0));
`else
      vt.push_back(mk(1'b0, 1'b1, HALF, 1'b1, 32'h0F, 32'h0, 1, 1, 32'h0, 1'b1, 32'h0, 1'b1));
`endif
      vt.push_back(mk(1'b0, 1'b1, FULL, 1'b0, 32'h10, 32'h0, 1, 1, 32'h8000_00F0, 1'b1, 32'h8877_6655, 1'b0));
      vt.push_back(st(FULL, 32'h00, 32'h0));
      vt.push_back(st(FULL, 32'h04, 32'h0));

      repeat (2) @(negedge clk);
      chk("rst_ready", {31'h0, bus_a.req_ready}, 32'h1);
      chk("rst_stall", {31'h0, bus_a.stall}, 32'h0);
      chk("rst_valid", {31'h0, bus_a.rdata_valid}, 32'h0);
      chk("rst_err", {31'h0, bus_a.misaligned_err}, 32'h0);
      chk("rst_rdata", bus_a.rdata, 32'h0);
      chk("rst_rdata_b", bus_b.rdata, 32'h0);
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_ready", {31'h0, bus_a.req_ready}, 32'h1);

      foreach (vt[i]) run_vec(i, vt[i]);

      // req_valid without either enable must be ignored
      drive(1'b1, 1'b0, 1'b0, FULL, 1'b0, 32'h10, 32'h0);
      @(posedge clk);
      #1;
      chk("noen_stall", {31'h0, bus_a.stall}, 32'h0);
      chk("noen_ready", {31'h0, bus_a.req_ready}, 32'h1);
      @(negedge clk);
      chk("noen_valid", {31'h0, bus_a.rdata_valid}, 32'h0);
      drive(1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 32'h0, 32'h0);
      @(negedge clk);

      // reset while the second half of a split halfword store is pending
      drive(1'b1, 1'b1, 1'b0, HALF, 1'b0, 32'h03, 32'h0000_CAFE);
      @(posedge clk);
      #1;
      drive(1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 32'h0, 32'h0);
      chk("sh3_stall", {31'h0, bus_a.stall}, {31'h0, SPLIT});
      chk("sh3_err", {31'h0, bus_a.misaligned_err}, {31'h0, !SPLIT});
      rst = 1'b1;
      #1;
      chk("mid_rst_stall", {31'h0, bus_a.stall}, 32'h0);
      chk("mid_rst_valid", {31'h0, bus_a.rdata_valid}, 32'h0);
      chk("mid_rst_err", {31'h0, bus_a.misaligned_err}, 32'h0);
      chk("mid_rst_rdata", bus_a.rdata, 32'h0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rel_ready", {31'h0, bus_a.req_ready}, 32'h1);
      @(negedge clk);
      run_vec(100, mk(1'b0, 1'b1, FULL, 1'b0, 32'h00, 32'h0, 1, 1,
                      SPLIT ? 32'hFE00_0000 : 32'h0, 1'b1, SPLIT ? 32'hFE00_0000 : 32'h0, 1'b0));
      run_vec(101, mk(1'b0, 1'b1, FULL, 1'b0, 32'h04, 32'h0, 1, 1, 32'h0, 1'b1, 32'h0, 1'b0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024, meaning the number of 32-bit data RAM words.
REQ-002 SHALL have parameter INIT_ZERO, default 1, meaning RAM contents are cleared to 0 at elaboration.
REQ-003 SHALL have port clk  in  1  meaning the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  in  1  meaning reset, asynchronous and active-high.
REQ-005 SHALL have ports req_valid in 1 (access request) and req_ready out 1 (request accepted this cycle).
REQ-006 SHALL have ports RAM_write_en in 1, RAM_read_en in 1, RAM_ram_type in 4 and RAM_sign in 1, using the BYTE/HALFWORD/FULLWORD encodings defined in GLOBALS.v.
REQ-007 SHALL have ports addr in 32 (byte address) and wdata in 32 (store data, right-aligned).
REQ-008 SHALL have ports rdata out 32 (load result, extended) and rdata_valid out 1 (one-cycle strobe).
REQ-009 SHALL have ports stall out 1 (pipeline hold) and misaligned_err out 1 (one-cycle strobe).

Function
REQ-010 SHALL accept a request when req_valid=1, req_ready=1 and (RAM_read_en or RAM_write_en) is 1; all other req_valid cycles are ignored.
REQ-011 SHALL use FSM states IDLE, ACC2 and RESP; req_ready=1 only in IDLE, and stall=1 in ACC2 and RESP.
REQ-012 SHALL use word index addr[31:2] modulo DEPTH_WORDS and byte lane addr[1:0].
REQ-013 SHALL treat an access as aligned when it is BYTE; HALFWORD with addr[0]=0; or FULLWORD with addr[1:0]=0.
REQ-014 SHALL, for an aligned store, write only the addressed byte lanes at the accepting edge; no response strobe; FSM stays IDLE.
REQ-015 SHALL, for an aligned load accepted at edge N, go IDLE->RESP and drive rdata_valid=1 with data in the cycle after N, then return to IDLE.
REQ-016 SHALL extract the load byte/halfword from the addressed lanes and sign-extend when RAM_sign=1, else zero-extend; FULLWORD is unchanged.
REQ-017 SHALL, when RAM_write_en and RAM_read_en are both 1, perform the store only and produce no rdata_valid.
REQ-018 SHALL hold rdata at its last value when rdata_valid=0.
REQ-019 SHALL wrap a word index at DEPTH_WORDS-1 to 0 for the second half of a split access.
REQ-020 SHALL ignore an unknown ram_type encoding with req accepted: no RAM write, and a load returns 0 with rdata_valid.

Reset
REQ-021 SHALL, on rst=1 at any time, force FSM=IDLE, rdata=0, rdata_valid=0, stall=0 and misaligned_err=0, and abandon any in-flight split access.
REQ-022 SHALL leave RAM contents unchanged by reset; a store whose first half completed before reset stays partially written.
REQ-023 SHALL drive req_ready=1 in the first cycle after rst deasserts.

Configuration
REQ-024 SHALL, with MISALIGNED_SPLIT_EN defined, split a misaligned access into word N at the accepting edge and word N+1 in ACC2: stores write both halves; loads merge the halves and assert rdata_valid two cycles after acceptance; misaligned_err stays 0.
REQ-025 SHALL, with MISALIGNED_SPLIT_EN undefined, drop a misaligned store; a misaligned load returns rdata=0 via RESP; misaligned_err pulses for 1 cycle after acceptance; ACC2 is unreachable.

Verification
REQ-026 SHALL cover: SW 0x8000_00F0 @0x10, then LB sign=1 @0x10 -> rdata=0xFFFF_FFF0 one cycle after acceptance, stall=1 for that cycle.
REQ-027 SHALL cover: SW 0x1234_5678 @0x20, SB 0xAB @0x21, LW @0x20 -> 0x1234_AB78; LHU @0x22 -> 0x0000_1234.
REQ-028 SHALL cover, with split enabled: SW 0x1122_3344 @0x4, SW 0x5566_7788 @0x8, LW @0x6 -> 0x7788_1122 two cycles after acceptance, stall=1 for 2 cycles; with split disabled -> rdata=0 and misaligned_err pulse.
REQ-029 SHALL cover: both enables with SW 0xDEAD_BEEF @0x30 -> no rdata_valid; a later LW @0x30 returns 0xDEAD_BEEF.
REQ-030 SHALL cover: rst asserted in ACC2 during a split SH 0xCAFE @0x3 -> outputs 0 immediately, only byte 0x3 = 0xFE written, req_ready=1 after release.
REQ-031 SHALL cover wrap: DEPTH_WORDS=4, split LH @0xF -> bytes merged from word 3 lane 3 and word 0 lane 0.
